stack_flagged: RTL and testbench
================================

Name: stack_flagged

Overview:
- Parametrised LIFO stack with occupancy tracking: full/empty flags, an occupancy count, a combinational top-of-stack peek, and overflow/underflow error pulses.
- A build-time mode selects between two full-stack policies: circular overwrite, or rejecting the push.
- Used as a return-address or data stack in small soft cores, in any place where a silent wrap is not acceptable.

Parameters:
- STACK_WIDTH, 18, bit width of each stored word.
- STACK_SIZE, 2, log2 of depth; DEPTH = 2**STACK_SIZE words; legal range 1..16.
- CIRCULAR, 0, full-stack policy: 1 = push when full overwrites the oldest entry; 0 = push when full is rejected.

Ports:
- i_clk  input  1  clock, all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_clear  input  1  synchronous flush; empties the stack.
- i_push  input  1  push request.
- i_pop  input  1  pop request.
- i_data  input  STACK_WIDTH  word to push.
- o_data  output  STACK_WIDTH  registered popped word.
- o_tos  output  STACK_WIDTH  combinational peek of the current top; undefined when o_empty.
- o_count  output  STACK_SIZE+1  number of valid entries, 0..DEPTH.
- o_empty  output  1  o_count == 0, combinational.
- o_full  output  1  o_count == DEPTH, combinational.
- o_overflow  output  1  one-cycle pulse: push while full.
- o_underflow  output  1  one-cycle pulse: pop while empty.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high; it sets the write pointer ptr=0, o_count=0, o_data=0, o_overflow=0 and o_underflow=0. Memory contents are not reset.
- Internal state: ptr (STACK_SIZE bits) is the next write slot. The top slot is ptr-1 modulo DEPTH. All pointer arithmetic wraps modulo DEPTH; count arithmetic is STACK_SIZE+1 bits wide.
- Error pulses: o_overflow and o_underflow default to 0 every cycle and are asserted only in the cycle after the offending request.
- Priority per cycle: i_clear first, then the push/pop combination.
- i_clear: ptr=0, count=0, o_data held, both pulses 0. Any push/pop in the same cycle is ignored.
- Push only, not full: mem[ptr]=i_data, ptr+1, count+1. o_data held.
- Push only, full, CIRCULAR=1: mem[ptr]=i_data, overwriting the oldest entry; ptr+1; count stays DEPTH; o_overflow=1.
- Push only, full, CIRCULAR=0: no write, no state change; o_overflow=1.
- Pop only, not empty: o_data=mem[ptr-1], ptr-1, count-1. The popped word appears on o_data one cycle after i_pop.
- Pop only, empty: no state change, o_data held, o_underflow=1. The pointer never wraps on underflow in either mode.
- Push+pop, not empty: o_data=mem[ptr-1] (the old top), mem[ptr-1]=i_data. ptr and count unchanged. No overflow, even when full.
- Push+pop, empty: o_data=i_data (pass-through), no write, count stays 0. No error pulse.
- o_tos = mem[ptr-1]. It reflects writes from the previous edge, with zero additional latency. The memory needs one read port for o_tos and one for the o_data path; it can share address ptr-1.
- Reset mid-operation: asynchronous assertion immediately forces the reset values above. After deassertion the stack is empty; old memory contents are not visible through o_count or o_empty.
- Formal: count <= DEPTH at all times; o_empty and o_full are never both 1; (ptr - count) mod DEPTH is stable except under circular overwrite.

Test Plan (STACK_WIDTH=8, STACK_SIZE=2, DEPTH=4):
- Reset then push 0x11, 0x22, 0x33 -> o_count=3, o_tos=0x33. Then pop x3 -> o_data=0x33, 0x22, 0x11 on consecutive cycles; o_empty=1.
- CIRCULAR=0: push 0x01..0x04, then push 0x05 -> o_full=1, o_overflow pulses once, o_tos=0x04. Pop x4 -> 0x04, 0x03, 0x02, 0x01.
- CIRCULAR=1: push 0x01..0x05 -> o_overflow pulses on the 5th push, o_count=4. Pop x4 -> 0x05, 0x04, 0x03, 0x02.
- Empty: pop -> o_underflow=1, o_data unchanged, o_count=0. Then push+pop with i_data=0xAA -> o_data=0xAA, o_count=0, no pulse.
- Push 0x10, 0x20, then push+pop with 0x99 -> o_data=0x20, o_tos=0x99, o_count=2. Pop -> o_data=0x99.
- Push 0x10, 0x20, then i_clear together with i_push -> o_count=0, o_empty=1. Push 0x30, 0x40, then assert i_rst between clock edges -> o_count=0, o_data=0 immediately, before the next edge.

Source files
------------

// File: rtl/stack_flagged.sv
// Parametrised LIFO stack with count, full/empty flags, a combinational top-of-stack
// peek and one-cycle overflow/underflow pulses; CIRCULAR picks the full-stack policy.
module stack_flagged #(
  parameter int STACK_WIDTH = 18,
  parameter int STACK_SIZE  = 2,
  parameter int CIRCULAR    = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [STACK_WIDTH-1:0] i_data,
  output logic [STACK_WIDTH-1:0] o_data,
  output logic [STACK_WIDTH-1:0] o_tos,
  output logic [STACK_SIZE:0]    o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int DEPTH = 2 ** STACK_SIZE;
  localparam logic [STACK_SIZE:0]   CNT_FULL = (STACK_SIZE + 1)'(DEPTH);
  localparam logic [STACK_SIZE:0]   CNT_ONE  = (STACK_SIZE + 1)'(1);
  localparam logic [STACK_SIZE-1:0] PTR_ONE  = STACK_SIZE'(1);

  logic [STACK_WIDTH-1:0] mem_q [DEPTH];

  logic [STACK_SIZE-1:0]  ptr_q, ptr_d;
  logic [STACK_SIZE:0]    count_q, count_d;
  logic [STACK_WIDTH-1:0] data_q, data_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  logic                   mem_we;
  logic [STACK_SIZE-1:0]  mem_waddr;
  logic [STACK_WIDTH-1:0] mem_wdata;

  logic [STACK_SIZE-1:0]  top;
  logic [STACK_WIDTH-1:0] top_word;
  logic                   empty;
  logic                   full;

  // The top slot sits just below the next write slot; both read ports share it.
  assign top      = ptr_q - PTR_ONE;
  assign top_word = mem_q[top];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = i_data;

    if (i_clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (i_push && i_pop) begin
      // Simultaneous push+pop replaces the top in place; on empty it is a pass-through.
      if (empty) begin
        data_d = i_data;
      end else begin
        data_d    = top_word;
        mem_we    = 1'b1;
        mem_waddr = top;
      end
    end else if (i_push) begin
      if (!full) begin
        mem_we  = 1'b1;
        ptr_d   = ptr_q + PTR_ONE;
        count_d = count_q + CNT_ONE;
      end else begin
        overflow_d = 1'b1;
        if (CIRCULAR != 0) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
        end
      end
    end else if (i_pop) begin
      if (!empty) begin
        data_d  = top_word;
        ptr_d   = top;
        count_d = count_q - CNT_ONE;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; emptiness is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign o_data      = data_q;
  assign o_tos       = top_word;
  assign o_count     = count_q;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_stack_flagged.sv
// Directed bench for stack_flagged: one reject-policy and one circular instance share
// the same stimulus; expected values are hand-computed constants.
module tb_stack_flagged;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_clear = 1'b0;
  logic       i_push = 1'b0;
  logic       i_pop = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic [7:0] data0, tos0, data1, tos1;
  logic [2:0] cnt0, cnt1;
  logic       emp0, full0, ovf0, unf0;
  logic       emp1, full1, ovf1, unf1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_flagged #(.STACK_WIDTH(8), .STACK_SIZE(2), .CIRCULAR(0)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_push(i_push), .i_pop(i_pop),
    .i_data(i_data), .o_data(data0), .o_tos(tos0), .o_count(cnt0), .o_empty(emp0),
    .o_full(full0), .o_overflow(ovf0), .o_underflow(unf0)
  );

  stack_flagged #(.STACK_WIDTH(8), .STACK_SIZE(2), .CIRCULAR(1)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_push(i_push), .i_pop(i_pop),
    .i_data(i_data), .o_data(data1), .o_tos(tos1), .o_count(cnt1), .o_empty(emp1),
    .o_full(full1), .o_overflow(ovf1), .o_underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, sample 1 ns after the edge, then return to idle.
  task automatic cyc(input logic pu, input logic po, input logic cl, input logic [7:0] d);
    i_push = pu; i_pop = po; i_clear = cl; i_data = d;
    @(posedge clk); #1;
    i_push = 1'b0; i_pop = 1'b0; i_clear = 1'b0;
  endtask

  task automatic check_both_cnt(input string tag, input logic [2:0] exp);
    check({tag, "_cnt0"}, 32'(cnt0), 32'(exp));
    check({tag, "_cnt1"}, 32'(cnt1), 32'(exp));
  endtask

  initial begin
    #12;
    check("rst_cnt0", 32'(cnt0), 0);
    check("rst_data0", 32'(data0), 0);
    check("rst_emp0", 32'(emp0), 1);
    check("rst_full0", 32'(full0), 0);
    check("rst_ovf1", 32'(ovf1), 0);
    check("rst_unf1", 32'(unf1), 0);
    i_rst = 1'b0;

    // Basic LIFO order
    cyc(1, 0, 0, 8'h11);
    check_both_cnt("push1", 3'd1);
    check("push1_tos0", 32'(tos0), 32'h11);
    cyc(1, 0, 0, 8'h22);
    cyc(1, 0, 0, 8'h33);
    check_both_cnt("push3", 3'd3);
    check("push3_tos0", 32'(tos0), 32'h33);
    check("push3_tos1", 32'(tos1), 32'h33);
    check("push3_emp0", 32'(emp0), 0);
    cyc(0, 1, 0, 8'h00);
    check("pop1_data0", 32'(data0), 32'h33);
    check("pop1_tos0", 32'(tos0), 32'h22);
    cyc(0, 1, 0, 8'h00);
    check("pop2_data0", 32'(data0), 32'h22);
    cyc(0, 1, 0, 8'h00);
    check("pop3_data0", 32'(data0), 32'h11);
    check("pop3_data1", 32'(data1), 32'h11);
    check("pop3_emp0", 32'(emp0), 1);
    check_both_cnt("pop3", 3'd0);

    // Underflow and empty pass-through
    cyc(0, 1, 0, 8'h00);
    check("unf_pulse0", 32'(unf0), 1);
    check("unf_pulse1", 32'(unf1), 1);
    check("unf_data0", 32'(data0), 32'h11);
    check_both_cnt("unf", 3'd0);
    cyc(0, 0, 0, 8'h00);
    check("unf_clear0", 32'(unf0), 0);
    cyc(1, 1, 0, 8'hAA);
    check("pass_data0", 32'(data0), 32'hAA);
    check("pass_data1", 32'(data1), 32'hAA);
    check_both_cnt("pass", 3'd0);
    check("pass_unf0", 32'(unf0), 0);
    check("pass_ovf0", 32'(ovf0), 0);

    // Fill, then push while full under both policies
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h02);
    cyc(1, 0, 0, 8'h03);
    cyc(1, 0, 0, 8'h04);
    check("fill_full0", 32'(full0), 1);
    check("fill_full1", 32'(full1), 1);
    check("fill_ovf0", 32'(ovf0), 0);
    check("fill_emp0", 32'(emp0), 0);
    cyc(1, 0, 0, 8'h05);
    check("ovf_pulse0", 32'(ovf0), 1);
    check("ovf_pulse1", 32'(ovf1), 1);
    check("ovf_tos0", 32'(tos0), 32'h04);
    check("ovf_tos1", 32'(tos1), 32'h05);
    check_both_cnt("ovf", 3'd4);
    cyc(0, 0, 0, 8'h00);
    check("ovf_once0", 32'(ovf0), 0);
    check("ovf_once1", 32'(ovf1), 0);
    cyc(0, 1, 0, 8'h00);
    check("drain1_data0", 32'(data0), 32'h04);
    check("drain1_data1", 32'(data1), 32'h05);
    cyc(0, 1, 0, 8'h00);
    check("drain2_data0", 32'(data0), 32'h03);
    check("drain2_data1", 32'(data1), 32'h04);
    cyc(0, 1, 0, 8'h00);
    check("drain3_data0", 32'(data0), 32'h02);
    check("drain3_data1", 32'(data1), 32'h03);
    cyc(0, 1, 0, 8'h00);
    check("drain4_data0", 32'(data0), 32'h01);
    check("drain4_data1", 32'(data1), 32'h02);
    check("drain_emp1", 32'(emp1), 1);
    check_both_cnt("drain", 3'd0);

    // Push+pop on a non-empty stack replaces the top
    cyc(1, 0, 0, 8'h10);
    cyc(1, 0, 0, 8'h20);
    cyc(1, 1, 0, 8'h99);
    check("swap_data0", 32'(data0), 32'h20);
    check("swap_data1", 32'(data1), 32'h20);
    check("swap_tos0", 32'(tos0), 32'h99);
    check("swap_tos1", 32'(tos1), 32'h99);
    check_both_cnt("swap", 3'd2);
    cyc(0, 1, 0, 8'h00);
    check("swap_pop_data0", 32'(data0), 32'h99);
    check("swap_pop_data1", 32'(data1), 32'h99);
    check_both_cnt("swap_pop", 3'd1);
    cyc(0, 1, 0, 8'h00);
    check("swap_pop2_data0", 32'(data0), 32'h10);

    // Clear wins over a simultaneous push
    cyc(1, 0, 0, 8'h10);
    cyc(1, 0, 0, 8'h20);
    cyc(1, 0, 1, 8'h55);
    check_both_cnt("clear", 3'd0);
    check("clear_emp0", 32'(emp0), 1);
    check("clear_emp1", 32'(emp1), 1);
    check("clear_data0", 32'(data0), 32'h10);

    // Push+pop while full: no overflow, top replaced
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h02);
    cyc(1, 0, 0, 8'h03);
    cyc(1, 0, 0, 8'h04);
    cyc(1, 1, 0, 8'h77);
    check("fullswap_data0", 32'(data0), 32'h04);
    check("fullswap_data1", 32'(data1), 32'h04);
    check("fullswap_ovf0", 32'(ovf0), 0);
    check("fullswap_ovf1", 32'(ovf1), 0);
    check("fullswap_tos0", 32'(tos0), 32'h77);
    check_both_cnt("fullswap", 3'd4);
    cyc(1, 0, 1, 8'h00);

    // Asynchronous reset between edges
    cyc(1, 0, 0, 8'h30);
    cyc(1, 0, 0, 8'h40);
    cyc(0, 1, 0, 8'h00);
    check("prerst_data0", 32'(data0), 32'h40);
    check_both_cnt("prerst", 3'd1);
    i_rst = 1'b1;
    #1;
    check_both_cnt("arst", 3'd0);
    check("arst_data0", 32'(data0), 0);
    check("arst_data1", 32'(data1), 0);
    check("arst_emp0", 32'(emp0), 1);
    #2;
    i_rst = 1'b0;
    cyc(0, 0, 0, 8'h00);
    check("postrst_emp1", 32'(emp1), 1);
    check("postrst_full1", 32'(full1), 0);
    check_both_cnt("postrst", 3'd0);
    cyc(0, 1, 0, 8'h00);
    check("postrst_unf0", 32'(unf0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
